// File: rtl/reg_wb_unit.sv
// Register-bank writeback arbiter: ALU results take priority, load results queue in a
// small in-order FIFO, and a 32-bit scoreboard tracks registers with pending writes.
module reg_wb_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issueValid,
    input  logic [4:0]               issueRd,
    input  logic                     aluValid,
    input  logic [4:0]               aluRd,
    input  logic [31:0]              aluData,
    input  logic                     memValid,
    input  logic [4:0]               memRd,
    input  logic [31:0]              memData,
    output logic                     memReady,
    output logic                     wrReg,
    output logic [4:0]               rd,
    output logic [31:0]              rdIn,
    output logic [31:0]              busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_reg_q, wr_reg_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   rd_in_q, rd_in_d;
    logic [31:0]   busy_q, busy_d;

    logic          alu_take, enq, deq, sel_valid;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;
    entry_t        head;

    assign memReady = (count_q < DEPTH_C);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        head      = fifo_q[rd_ptr_q];
        alu_take  = aluValid && (aluRd != 5'd0);
        deq       = !alu_take && (count_q != '0);
        enq       = memValid && memReady && (memRd != 5'd0);
        sel_valid = alu_take || deq;
        sel_rd    = alu_take ? aluRd   : head.rd;
        sel_data  = alu_take ? aluData : head.data;

        wr_reg_d  = sel_valid;
        rd_d      = sel_valid ? sel_rd   : rd_q;
        rd_in_d   = sel_valid ? sel_data : rd_in_q;

        wr_ptr_d  = enq ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = deq ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d   = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Clear before set so a same-edge issue to the written register keeps it busy.
        busy_d = busy_q;
        if (sel_valid) busy_d[sel_rd] = 1'b0;
        if (issueValid && (issueRd != 5'd0)) busy_d[issueRd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_reg_q <= 1'b0;
            rd_q     <= '0;
            rd_in_q  <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wr_reg_q <= wr_reg_d;
            rd_q     <= rd_d;
            rd_in_q  <= rd_in_d;
            busy_q   <= busy_d;
        end
    end

    // NOTE: FIFO storage is not reset; resetting the pointers and count is enough to discard it.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            fifo_q[wr_ptr_q] <= '{rd: memRd, data: memData};
        end
    end

    assign wrReg = wr_reg_q;
    assign rd    = rd_q;
    assign rdIn  = rd_in_q;
    assign busy  = busy_q;
    assign count = count_q;

endmodule
